adc_stream_ctrl: RTL

Write-side controller between the dual 12-bit ADC inputs and the async FIFO write port, in the clk_data domain.
- Selects channel mode: dual, ch0-packed or ch1-packed.
- Frames samples into packets: one header word followed by PKT_WORDS data words.
- Sequences start and stop.
- On FIFO overflow, drops data cleanly and flags the loss in the next header, so the host-side parser can resynchronise.

---
 rtl/adc_stream_ctrl.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/adc_stream_ctrl.sv
// -----------------------------------------------------------------------------
// adc_stream_ctrl
//
// Write-side controller between the dual 12-bit ADC inputs and the async FIFO
// write port, entirely in the clk_data domain. Frames samples into packets of
// one header word plus PKT_WORDS data words, sequences start/stop, and on FIFO
// overflow drops data until the FIFO drains below almost-full, marking the
// loss in the next header so the host parser can resynchronise.
//
// Header word: {4'hA, mode[1:0], drop_flag, 1'b0, seq[15:0]}
//
// Optional feature (macro STREAM_TESTPAT_EN): adds input testpat, latched with
// mode in IDLE. When latched high the ADC samples are replaced by a 12-bit
// counter (adc0 path = cnt, adc1 path = ~cnt) that restarts at 0 on every
// header-to-data transition and advances once per data-state cycle.
//
// Ports:
//   clk_data    in   data/ADC clock, rising edge
//   rstn        in   asynchronous active-low reset
//   enable      in   stream enable (level)
//   mode[1:0]   in   0=dual {adc0,adc1}, 1=ch0 packed, 2=ch1 packed, 3=as 0
//   adc0_data   in   ADC0 sample, valid every cycle
//   adc1_data   in   ADC1 sample, valid every cycle
//   fifo_full   in   FIFO full flag
//   fifo_afull  in   FIFO almost-full flag
//   testpat     in   test-pattern select (only with STREAM_TESTPAT_EN)
//   fifo_wdata  out  FIFO write data (holds last written word between writes)
//   fifo_winc   out  FIFO write strobe
//   ovf_count   out  saturating overflow event counter
//   streaming   out  high whenever the controller is not idle
//   dbg_state   out  current FSM state (0=IDLE 1=HDR 2=DATA 3=DROP)
//
// Handshake: the FIFO port is a push-only strobe. fifo_winc is registered and
// a write is only launched in a cycle where fifo_full was low at the decision
// edge; there is no other back-pressure than fifo_full / fifo_afull.
// -----------------------------------------------------------------------------
module adc_stream_ctrl #(
  parameter int unsigned PKT_WORDS = 1982,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk_data,
  input  logic             rstn,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [11:0]      adc0_data,
  input  logic [11:0]      adc1_data,
  input  logic             fifo_full,
  input  logic             fifo_afull,
`ifdef STREAM_TESTPAT_EN
  input  logic             testpat,
`endif
  output logic [23:0]      fifo_wdata,
  output logic             fifo_winc,
  output logic [CNT_W-1:0] ovf_count,
  output logic             streaming,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2,
    ST_DROP = 2'd3
  } state_t;

  localparam logic [15:0] LAST_WORD = 16'(PKT_WORDS - 1);

  state_t             state_q, state_d;
  logic [1:0]         mode_l_q, mode_l_d;
  logic [15:0]        seq_q, seq_d;
  logic               drop_flag_q, drop_flag_d;
  logic [15:0]        word_cnt_q, word_cnt_d;
  logic               phase_q, phase_d;
  logic [11:0]        hold_q, hold_d;
  logic [11:0]        s0_q, s1_q;
  logic [23:0]        wdata_q, wdata_d;
  logic               winc_q, winc_d;
  logic [CNT_W-1:0]   ovf_q, ovf_d;

  // Effective sample pair seen by the packer (ADC or test pattern).
  logic [11:0]        smp0, smp1;
  logic [11:0]        sel_smp;
  logic               write_due;
  logic [23:0]        data_word;
  logic               ovf_event;

`ifdef STREAM_TESTPAT_EN
  logic               tp_l_q, tp_l_d;
  logic [11:0]        tp_cnt_q, tp_cnt_d;

  always_comb begin
    tp_l_d   = tp_l_q;
    tp_cnt_d = tp_cnt_q;
    if (state_q == ST_IDLE && enable) begin
      tp_l_d = testpat;
    end
    if (state_q == ST_HDR && !fifo_full) begin
      tp_cnt_d = 12'd0;
    end else if (state_q == ST_DATA) begin
      tp_cnt_d = tp_cnt_q + 12'd1;
    end
  end

  always_ff @(posedge clk_data or negedge rstn) begin
    if (!rstn) begin
      tp_l_q   <= 1'b0;
      tp_cnt_q <= 12'd0;
    end else begin
      tp_l_q   <= tp_l_d;
      tp_cnt_q <= tp_cnt_d;
    end
  end

  assign smp0 = tp_l_q ? tp_cnt_q  : s0_q;
  assign smp1 = tp_l_q ? ~tp_cnt_q : s1_q;
`else
  assign smp0 = s0_q;
  assign smp1 = s1_q;
`endif

  // mode_l is normalised at latch time, so 2 is the only ch1 encoding.
  assign sel_smp = (mode_l_q == 2'd2) ? smp1 : smp0;

  always_comb begin
    state_d     = state_q;
    mode_l_d    = mode_l_q;
    seq_d       = seq_q;
    drop_flag_d = drop_flag_q;
    word_cnt_d  = word_cnt_q;
    phase_d     = phase_q;
    hold_d      = hold_q;
    wdata_d     = wdata_q;
    winc_d      = 1'b0;
    write_due   = 1'b0;
    data_word   = 24'd0;
    ovf_event   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          mode_l_d    = (mode == 2'd3) ? 2'd0 : mode;
          seq_d       = 16'd0;
          drop_flag_d = 1'b0;
          state_d     = ST_HDR;
        end
      end

      ST_HDR: begin
        // The sample present during this cycle is intentionally not used.
        if (!fifo_full) begin
          winc_d      = 1'b1;
          wdata_d     = {4'hA, mode_l_q, drop_flag_q, 1'b0, seq_q};
          seq_d       = seq_q + 16'd1;
          drop_flag_d = 1'b0;
          word_cnt_d  = 16'd0;
          phase_d     = 1'b0;
          state_d     = ST_DATA;
        end else begin
          ovf_event = 1'b1;
          state_d   = ST_DROP;
        end
      end

      ST_DATA: begin
        if (mode_l_q == 2'd0) begin
          write_due = 1'b1;
          data_word = {smp0, smp1};
        end else if (!phase_q) begin
          // First half of a packed pair: park it, nothing to write yet.
          hold_d  = sel_smp;
          phase_d = 1'b1;
        end else begin
          write_due = 1'b1;
          data_word = {hold_q, sel_smp};
        end

        if (write_due) begin
          if (fifo_full) begin
            ovf_event = 1'b1;
            state_d   = ST_DROP;
          end else begin
            winc_d  = 1'b1;
            wdata_d = data_word;
            phase_d = 1'b0;
            if (word_cnt_q == LAST_WORD) begin
              // A stop request only takes effect at a packet boundary.
              state_d = enable ? ST_HDR : ST_IDLE;
            end else begin
              word_cnt_d = word_cnt_q + 16'd1;
            end
          end
        end
      end

      ST_DROP: begin
        drop_flag_d = 1'b1;
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (!fifo_afull) begin
          state_d = ST_HDR;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ovf_d = ovf_q;
    if (ovf_event && (ovf_q != {CNT_W{1'b1}})) begin
      ovf_d = ovf_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_data or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      mode_l_q    <= 2'd0;
      seq_q       <= 16'd0;
      drop_flag_q <= 1'b0;
      word_cnt_q  <= 16'd0;
      phase_q     <= 1'b0;
      hold_q      <= 12'd0;
      s0_q        <= 12'd0;
      s1_q        <= 12'd0;
      wdata_q     <= 24'd0;
      winc_q      <= 1'b0;
      ovf_q       <= '0;
    end else begin
      state_q     <= state_d;
      mode_l_q    <= mode_l_d;
      seq_q       <= seq_d;
      drop_flag_q <= drop_flag_d;
      word_cnt_q  <= word_cnt_d;
      phase_q     <= phase_d;
      hold_q      <= hold_d;
      s0_q        <= adc0_data;
      s1_q        <= adc1_data;
      wdata_q     <= wdata_d;
      winc_q      <= winc_d;
      ovf_q       <= ovf_d;
    end
  end

  assign fifo_wdata = wdata_q;
  assign fifo_winc  = winc_q;
  assign ovf_count  = ovf_q;
  assign streaming  = (state_q != ST_IDLE);
  assign dbg_state  = state_q;

endmodule
